// File: rtl/ecc_dcd_collect.sv
// ecc_dcd_collect: collection stage behind the Golay(24,12) PROM ECC decoder.
// A valid strobe is delayed to line up with the decoder outputs. Decoded words
// are written sequentially into the constants register file, and good and
// uncorrectable words are counted. A block of NWORDS words runs from START to
// DONE, or to ABORT on the first bad word when STOP_ON_BAD is set.
//
// Handshake: there is no backpressure. RCV_VLD marks a real word at the decoder
// input. WR_EN is a one-cycle strobe that the register file must accept at once.
module ecc_dcd_collect #(
    parameter int DCD_LAT     = 6,
    parameter int NWORDS      = 64,
    parameter int AW          = 6,
    parameter bit STOP_ON_BAD = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic          RCV_VLD,
    input  logic [11:0]   DCD_DATA,
    input  logic          GOOD_WORD,
    input  logic          BAD_TX,
    output logic          WR_EN,
    output logic [AW-1:0] WR_ADDR,
    output logic [11:0]   WR_DATA,
    output logic          BUSY,
    output logic          DONE,
    output logic          ABORT,
    output logic [7:0]    GOOD_CNT,
    output logic [7:0]    BAD_CNT,
    output logic [2:0]    DBG_STATE
);

    localparam int            CW     = $clog2(NWORDS + 1);
    localparam logic [CW-1:0] N_LAST = CW'(NWORDS);
    localparam logic [CW-1:0] N_M1   = CW'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      issue_cnt;
    logic [CW-1:0]      rcv_cnt;
    logic [AW-1:0]      addr;
    logic [DCD_LAT-1:0] dly;
    logic               start_ok;
    logic               enter;
    logic               vld_d;
    logic               proc;
    logic               good;
    logic               abort_now;

    // START only counts when no block is in progress.
    assign start_ok  = START && (state == S_IDLE || state == S_DONE || state == S_ABORT);
    // A word enters the delay line only while the block still wants words.
    assign enter     = RCV_VLD && (state == S_RUN) && (issue_cnt < N_LAST);
    // Tap of the delay line, aligned with the decoder outputs.
    assign vld_d     = dly[DCD_LAT-1];
    assign proc      = vld_d && (state == S_RUN || state == S_DRAIN);
    // A word with neither flag set is treated as bad.
    assign good      = GOOD_WORD && !BAD_TX;
    assign abort_now = STOP_ON_BAD && proc && !good;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort outranks both the drain and done transitions.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ABORT: if (START) state_nxt = S_RUN;
            S_RUN: begin
                if (abort_now)                         state_nxt = S_ABORT;
                else if (enter && (issue_cnt == N_M1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_now)                 state_nxt = S_ABORT;
                else if (rcv_cnt == N_LAST)    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        BUSY      = (state == S_RUN) || (state == S_DRAIN);
        DONE      = (state == S_DONE);
        ABORT     = (state == S_ABORT);
        DBG_STATE = state;
    end

    // Delay line, counters, address and the registered write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            addr      <= '0;
            dly       <= '0;
            WR_EN     <= 1'b0;
            WR_ADDR   <= '0;
            WR_DATA   <= '0;
            GOOD_CNT  <= '0;
            BAD_CNT   <= '0;
        end else if (start_ok) begin
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            addr      <= '0;
            dly       <= '0;
            WR_EN     <= 1'b0;
            GOOD_CNT  <= '0;
            BAD_CNT   <= '0;
        end else begin
            WR_EN <= proc && good;
            if (enter) issue_cnt <= issue_cnt + 1'b1;
            // An abort drops every word still in flight.
            if (abort_now) begin
                dly <= '0;
            end else begin
                dly[0] <= enter;
                for (int k = 1; k < DCD_LAT; k++) dly[k] <= dly[k-1];
            end
            // Bad words still consume an address so the PROM layout is preserved.
            if (proc) begin
                rcv_cnt <= rcv_cnt + 1'b1;
                addr    <= addr + 1'b1;
                if (good) begin
                    WR_ADDR <= addr;
                    WR_DATA <= DCD_DATA;
                    if (GOOD_CNT != 8'hFF) GOOD_CNT <= GOOD_CNT + 8'd1;
                end else begin
                    if (BAD_CNT != 8'hFF) BAD_CNT <= BAD_CNT + 8'd1;
                end
            end
        end
    end

endmodule
